// File: rtl/dac_spi_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | dac_spi_pkg                                                      |
// | Shared constants and FSM encoding for the DAC SPI transmitter.   |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package dac_spi_pkg;

    localparam int FRAME_BITS          = 32;
    localparam int FRAMES_HALF_PERIODS = 66;
    localparam int HALF_CNT_W          = 8;
    localparam int BIT_CNT_W           = 6;

    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(FRAME_BITS - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        SHIFT = 3'd2,
        HOLD  = 3'd3,
        GAP   = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/dac_spi_tx_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | dac_spi_tx_if                                                    |
// | Sample handshake and DAC pin bundle for dac_spi_tx.              |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
interface dac_spi_tx_if;

    logic [31:0] sample_in;
    logic        sample_valid;
    logic        sample_ready;
    logic        sclk;
    logic        mosi;
    logic        cs_n;
    logic        busy;
    logic        done;

    modport slave (
        input  sample_in,
        input  sample_valid,
        output sample_ready,
        output sclk,
        output mosi,
        output cs_n,
        output busy,
        output done
    );

    modport master (
        output sample_in,
        output sample_valid,
        input  sample_ready,
        input  sclk,
        input  mosi,
        input  cs_n,
        input  busy,
        input  done
    );

endinterface
`default_nettype wire

// File: rtl/spi_sclk_gen.sv
`default_nettype none
// +------------------------------------------------------------------+
// | spi_sclk_gen                                                     |
// | Half-period timer emitting SCLK phase strobes while enabled.     |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module spi_sclk_gen
    import dac_spi_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic rise_stb,
    output logic fall_stb,
    output logic phase_end
);

    localparam logic [HALF_CNT_W-1:0] C_LAST = HALF_CNT_W'(CLK_DIV - 1);

    logic [HALF_CNT_W-1:0] r_cnt;
    logic                  r_phase;

    // Phase 0 is the low half; disabling parks the timer at the start of a low half.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt   <= '0;
            r_phase <= 1'b0;
        end else if (!en) begin
            r_cnt   <= '0;
            r_phase <= 1'b0;
        end else if (r_cnt == C_LAST) begin
            r_cnt   <= '0;
            r_phase <= ~r_phase;
        end else begin
            r_cnt   <= r_cnt + 1'b1;
        end
    end

    assign phase_end = en && (r_cnt == C_LAST);
    assign rise_stb  = phase_end && !r_phase;
    assign fall_stb  = phase_end &&  r_phase;

endmodule
`default_nettype wire

// File: rtl/dac_spi_tx.sv
`default_nettype none
// +------------------------------------------------------------------+
// | dac_spi_tx                                                       |
// | SPI mode-0 MSB-first transmitter, one 32-bit word per CS frame.  |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module dac_spi_tx
    import dac_spi_pkg::*;
#(
    parameter int CLK_DIV = 4,
    parameter int CS_GAP  = 2
) (
    input  logic         clk,
    input  logic         reset,
    dac_spi_tx_if.slave  bus
);

    localparam logic [HALF_CNT_W-1:0] C_GAP_LAST = HALF_CNT_W'(CS_GAP - 1);

    state_t                 r_state, w_state_nxt;
    logic [FRAME_BITS-1:0]  r_shreg, w_shreg_nxt;
    logic [BIT_CNT_W-1:0]   r_bit_cnt, w_bit_cnt_nxt;
    logic [HALF_CNT_W-1:0]  r_gap_cnt, w_gap_cnt_nxt;
    logic                   r_ready, w_ready_nxt;
    logic                   r_sclk, w_sclk_nxt;
    logic                   r_mosi, w_mosi_nxt;
    logic                   r_cs_n, w_cs_n_nxt;
    logic                   r_busy, w_busy_nxt;
    logic                   r_done, w_done_nxt;

    logic w_accept;
    logic w_gen_en;
    logic w_rise;
    logic w_fall;
    logic w_phase_end;

    assign w_accept = (r_state == IDLE) && r_ready && bus.sample_valid;
    assign w_gen_en = (r_state == SETUP) || (r_state == SHIFT) || (r_state == HOLD);

    spi_sclk_gen #(
        .CLK_DIV   (CLK_DIV)
    ) u_sclk_gen (
        .clk       (clk),
        .reset     (reset),
        .en        (w_gen_en),
        .rise_stb  (w_rise),
        .fall_stb  (w_fall),
        .phase_end (w_phase_end)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_shreg   <= '0;
            r_bit_cnt <= '0;
            r_gap_cnt <= '0;
            r_ready   <= 1'b0;
            r_sclk    <= 1'b0;
            r_mosi    <= 1'b0;
            r_cs_n    <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_shreg   <= w_shreg_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_gap_cnt <= w_gap_cnt_nxt;
            r_ready   <= w_ready_nxt;
            r_sclk    <= w_sclk_nxt;
            r_mosi    <= w_mosi_nxt;
            r_cs_n    <= w_cs_n_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
        end
    end

    // The rise strobe that would start a 33rd period is what ends SHIFT.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept)                            w_state_nxt = SETUP;
            SETUP:   if (w_rise)                              w_state_nxt = SHIFT;
            SHIFT:   if (w_rise && (r_bit_cnt == LAST_BIT))   w_state_nxt = HOLD;
            HOLD:    if (w_phase_end)                         w_state_nxt = GAP;
            GAP:     if (r_gap_cnt == C_GAP_LAST)             w_state_nxt = IDLE;
            default:                                          w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_shreg_nxt   = r_shreg;
        w_bit_cnt_nxt = r_bit_cnt;
        w_gap_cnt_nxt = r_gap_cnt;
        w_ready_nxt   = r_ready;
        w_sclk_nxt    = r_sclk;
        w_mosi_nxt    = r_mosi;
        w_cs_n_nxt    = r_cs_n;
        w_busy_nxt    = r_busy;
        w_done_nxt    = 1'b0;
        case (r_state)
            IDLE: begin
                w_ready_nxt = 1'b1;
                if (w_accept) begin
                    w_shreg_nxt   = bus.sample_in;
                    w_bit_cnt_nxt = '0;
                    w_ready_nxt   = 1'b0;
                    w_busy_nxt    = 1'b1;
                    w_cs_n_nxt    = 1'b0;
                    w_mosi_nxt    = bus.sample_in[FRAME_BITS-1];
                end
            end
            SETUP: begin
                if (w_rise) w_sclk_nxt = 1'b1;
            end
            SHIFT: begin
                // Rotating keeps the register MSB-aligned with mosi after each step.
                if (w_fall) begin
                    w_sclk_nxt = 1'b0;
                    if (r_bit_cnt != LAST_BIT) begin
                        w_shreg_nxt = {r_shreg[FRAME_BITS-2:0], r_shreg[FRAME_BITS-1]};
                        w_mosi_nxt  = r_shreg[FRAME_BITS-2];
                    end
                end
                if (w_rise && (r_bit_cnt != LAST_BIT)) begin
                    w_sclk_nxt    = 1'b1;
                    w_bit_cnt_nxt = r_bit_cnt + 1'b1;
                end
            end
            HOLD: begin
                if (w_phase_end) begin
                    w_cs_n_nxt    = 1'b1;
                    w_done_nxt    = 1'b1;
                    w_mosi_nxt    = 1'b0;
                    w_gap_cnt_nxt = '0;
                end
            end
            GAP: begin
                if (r_gap_cnt == C_GAP_LAST) begin
                    w_ready_nxt = 1'b1;
                    w_busy_nxt  = 1'b0;
                end else begin
                    w_gap_cnt_nxt = r_gap_cnt + 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign bus.sample_ready = r_ready;
    assign bus.sclk         = r_sclk;
    assign bus.mosi         = r_mosi;
    assign bus.cs_n         = r_cs_n;
    assign bus.busy         = r_busy;
    assign bus.done         = r_done;

endmodule
`default_nettype wire

// File: tb/tb_dac_spi_tx.sv
`default_nettype none
`timescale 1ns/1ps
// +------------------------------------------------------------------+
// | tb_dac_spi_tx                                                    |
// | Scoreboard bench: CLK_DIV=4 and CLK_DIV=1 instances of dac_spi_tx|
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module tb_dac_spi_tx;
    import dac_spi_pkg::*;

    localparam int G = 2;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   cyc   = 0;
    int   n_pass  = 0;
    int   n_total = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dac_spi_tx_if bus0();
    dac_spi_tx_if bus1();

    dac_spi_tx #(.CLK_DIV(4), .CS_GAP(G)) u_dut4 (.clk(clk), .reset(reset), .bus(bus0.slave));
    dac_spi_tx #(.CLK_DIV(1), .CS_GAP(G)) u_dut1 (.clk(clk), .reset(reset), .bus(bus1.slave));

    wire [1:0] m_sclk = {bus1.sclk, bus0.sclk};
    wire [1:0] m_mosi = {bus1.mosi, bus0.mosi};
    wire [1:0] m_csn  = {bus1.cs_n, bus0.cs_n};
    wire [1:0] m_done = {bus1.done, bus0.done};
    wire [1:0] m_busy = {bus1.busy, bus0.busy};

    logic [31:0] q0[$];
    logic [31:0] q1[$];

    int          div [2] = '{4, 1};
    int          low_cnt [2], rises [2], mosi_hi [2], last_mosi_hi [2];
    int          hi_gap [2], last_gap [2], acc_cyc [2], last_interval [2];
    int          accepts [2], done_cnt [2], last_rise_cyc [2];
    logic        bad_period [2];
    logic [31:0] cap [2];
    logic        prev_sclk [2], prev_csn [2], prev_busy [2];
    logic        abort [2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            low_cnt[k] = 0; rises[k] = 0; mosi_hi[k] = 0; last_mosi_hi[k] = 0;
            hi_gap[k] = 0; last_gap[k] = 0; acc_cyc[k] = 0; last_interval[k] = 0;
            accepts[k] = 0; done_cnt[k] = 0; last_rise_cyc[k] = 0;
            bad_period[k] = 1'b0; cap[k] = '0;
            prev_sclk[k] = 1'b0; prev_csn[k] = 1'b1; prev_busy[k] = 1'b0; abort[k] = 1'b0;
        end
    end

    // Monitor: reconstructs each frame from the pins and scores it against the queue.
    always @(negedge clk) begin : p_mon
        logic [31:0] exp_w;
        logic        have;
        for (int k = 0; k < 2; k++) begin
            if (m_done[k]) done_cnt[k]++;
            if (m_busy[k] && !prev_busy[k]) begin
                if (accepts[k] > 0) last_interval[k] = cyc - acc_cyc[k];
                acc_cyc[k] = cyc;
                accepts[k]++;
            end
            if (!m_csn[k]) begin
                if (prev_csn[k]) begin
                    last_gap[k] = hi_gap[k];
                    low_cnt[k] = 0; rises[k] = 0; mosi_hi[k] = 0;
                    cap[k] = '0; bad_period[k] = 1'b0;
                end
                low_cnt[k]++;
                if (m_mosi[k]) mosi_hi[k]++;
                if (m_sclk[k] && !prev_sclk[k]) begin
                    if (rises[k] > 0 && (cyc - last_rise_cyc[k]) != 2 * div[k]) bad_period[k] = 1'b1;
                    last_rise_cyc[k] = cyc;
                    cap[k] = {cap[k][30:0], m_mosi[k]};
                    rises[k]++;
                end
            end else begin
                if (!prev_csn[k]) begin
                    have = 1'b0;
                    exp_w = '0;
                    if (k == 0 && q0.size() > 0) begin exp_w = q0.pop_front(); have = 1'b1; end
                    if (k == 1 && q1.size() > 0) begin exp_w = q1.pop_front(); have = 1'b1; end
                    if (abort[k]) begin
                        check($sformatf("d%0d_abort_no_done", k), 32'(m_done[k]), 32'd0);
                        abort[k] = 1'b0;
                    end else begin
                        check($sformatf("d%0d_frame_expected", k), 32'(have), 32'd1);
                        check($sformatf("d%0d_word", k), cap[k], exp_w);
                        check($sformatf("d%0d_rises", k), 32'(rises[k]), 32'd32);
                        check($sformatf("d%0d_cs_low_cycles", k), 32'(low_cnt[k]), 32'(FRAMES_HALF_PERIODS * div[k]));
                        check($sformatf("d%0d_sclk_period", k), 32'(bad_period[k]), 32'd0);
                        check($sformatf("d%0d_done_at_end", k), 32'(m_done[k]), 32'd1);
                        check($sformatf("d%0d_done_cycle", k), 32'(cyc - acc_cyc[k]), 32'(FRAMES_HALF_PERIODS * div[k]));
                        last_mosi_hi[k] = mosi_hi[k];
                    end
                    hi_gap[k] = 0;
                end
                hi_gap[k]++;
            end
            prev_sclk[k] = m_sclk[k];
            prev_csn[k]  = m_csn[k];
            prev_busy[k] = m_busy[k];
        end
    end

    function automatic logic busy_of(input int k);
        return (k == 0) ? bus0.busy : bus1.busy;
    endfunction

    task automatic drive(input int k, input logic v, input logic [31:0] w);
        if (k == 0) begin bus0.sample_valid = v; bus0.sample_in = w; end
        else        begin bus1.sample_valid = v; bus1.sample_in = w; end
    endtask

    task automatic push(input int k, input logic [31:0] w);
        if (k == 0) q0.push_back(w);
        else        q1.push_back(w);
    endtask

    task automatic wait_busy(input int k, input logic lvl, input string name);
        int n;
        n = 0;
        while (busy_of(k) !== lvl && n < 2000) begin @(negedge clk); n++; end
        if (n >= 2000) check({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic send(input int k, input logic [31:0] w);
        @(negedge clk);
        drive(k, 1'b1, w);
        push(k, w);
        wait_busy(k, 1'b1, "accept");
        drive(k, 1'b0, w);
    endtask

    initial begin : p_watchdog
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : p_stim
        int d0, a0, bad, n;
        drive(0, 1'b0, '0);
        drive(1, 1'b0, '0);
        #1 reset = 1'b1;
        repeat (3) @(negedge clk);

        // Reset state and ready timing
        check("rst_ready", 32'(bus0.sample_ready), 32'd0);
        check("rst_cs_n", {30'd0, bus1.cs_n, bus0.cs_n}, 32'd3);
        check("rst_sclk_mosi", {28'd0, bus1.sclk, bus1.mosi, bus0.sclk, bus0.mosi}, 32'd0);
        check("rst_busy_done", {28'd0, bus1.busy, bus1.done, bus0.busy, bus0.done}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("ready_after_release", {30'd0, bus1.sample_ready, bus0.sample_ready}, 32'd3);
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (bus0.sample_ready !== 1'b1 || bus0.cs_n !== 1'b1 || bus0.busy !== 1'b0) bad++;
        end
        check("idle_hold_100", 32'(bad), 32'd0);

        // Single word, CLK_DIV=4
        d0 = done_cnt[0];
        send(0, 32'hA5A5_0F0F);
        wait_busy(0, 1'b0, "frame_a5");
        check("done_once", 32'(done_cnt[0] - d0), 32'd1);

        // Back-to-back with sample_valid held high
        @(negedge clk);
        a0 = accepts[0];
        drive(0, 1'b1, 32'h0000_0001);
        push(0, 32'h0000_0001);
        push(0, 32'hFFFF_FFFF);
        wait_busy(0, 1'b1, "b2b_first");
        drive(0, 1'b1, 32'hFFFF_FFFF);
        n = 0;
        while (accepts[0] < a0 + 2 && n < 2000) begin @(negedge clk); n++; end
        if (n >= 2000) check("b2b_second_timeout", 32'd0, 32'd1);
        drive(0, 1'b0, '0);
        check("b2b_interval", 32'(last_interval[0]), 32'(FRAMES_HALF_PERIODS * 4 + G + 1));
        check("b2b_cs_high", 32'(last_gap[0]), 32'(G + 1));
        wait_busy(0, 1'b0, "b2b_end");

        // CLK_DIV=1 single MSB
        send(1, 32'h8000_0000);
        wait_busy(1, 1'b0, "div1_end");
        check("div1_mosi_hi_cycles", 32'(last_mosi_hi[1]), 32'd2);

        // Reset mid-frame
        send(0, 32'h1234_5678);
        repeat (98) @(negedge clk);
        d0 = done_cnt[0];
        #2;
        check("mid_frame_active", 32'(bus0.cs_n), 32'd0);
        abort[0] = 1'b1;
        reset = 1'b1;
        #1;
        check("async_cs_n", 32'(bus0.cs_n), 32'd1);
        check("async_sclk_mosi", {30'd0, bus0.sclk, bus0.mosi}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        check("abort_no_done_cnt", 32'(done_cnt[0] - d0), 32'd0);
        send(0, 32'h0000_ABCD);
        wait_busy(0, 1'b0, "post_reset_end");

        // Noisy sample_valid / sample_in while busy
        a0 = accepts[0];
        send(0, 32'hC3C3_5AA5);
        n = 0;
        while (n < 2000) begin
            @(negedge clk);
            n++;
            if (bus0.busy === 1'b1) drive(0, 1'($urandom_range(0, 1)), $urandom);
            else begin drive(0, 1'b0, '0); break; end
        end
        if (n >= 2000) check("noise_timeout", 32'd0, 32'd1);
        repeat (10) @(negedge clk);
        check("noise_single_accept", 32'(accepts[0] - a0), 32'd1);

        check("queues_drained", 32'(q0.size() + q1.size()), 32'd0);
        check("total_accepts", {accepts[1][15:0], accepts[0][15:0]}, {16'd1, 16'd6});

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
